// File: rtl/store_monitor_pkg.sv
// store_monitor_pkg: shared types for the store-side self-test monitor
package store_monitor_pkg;
  typedef enum logic [1:0] {RUN, PASS, FAIL} mon_state_t;
  typedef enum logic [1:0] {FC_NONE, FC_BAD_ADR, FC_BAD_DATA, FC_TIMEOUT} fail_code_t;
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
  } store_rec_t;
endpackage

// File: rtl/store_log_fifo.sv
// store_log_fifo: first-word-fall-through store log with sticky overflow flag
module store_log_fifo
  import store_monitor_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       rd_en,
  input  store_rec_t wr_rec,
  output logic       valid,
  output store_rec_t rd_rec,
  output logic       overflow
);
  localparam int AW = $clog2(DEPTH);
  store_rec_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic full, pop, push;
  assign valid = cnt != '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign pop = rd_en && valid;
  // a full log still accepts a push when the same edge frees a slot
  assign push = wr_en && (!full || pop);
  assign rd_rec = mem[rp];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (wr_en && full && !pop) overflow <= 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= wr_rec;
endmodule

// File: rtl/store_monitor.sv
// store_monitor: decides pass/fail of the self-test from data-memory stores and logs every store
module store_monitor
  import store_monitor_pkg::*;
#(
  parameter logic [31:0] PASS_ADDR      = 32'd100,
  parameter logic [31:0] PASS_DATA      = 32'd3,
  parameter logic [31:0] SCRATCH_ADDR   = 32'd96,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int          LOG_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] data_adr,
  input  logic [31:0] write_data,
  input  logic        log_rd_en,
  output logic        log_valid,
  output logic [31:0] log_adr,
  output logic [31:0] log_data,
  output logic        log_overflow,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [1:0]  fail_code,
  output logic [31:0] fail_adr,
  output logic [31:0] fail_data,
  output logic [31:0] cycle_count
);
  mon_state_t state, state_n;
  fail_code_t code_n, code_q;
  store_rec_t head;
  logic decide, timeout;
  store_log_fifo #(.DEPTH(LOG_DEPTH)) u_log (
    .clk(clk), .reset(reset), .wr_en(mem_write), .rd_en(log_rd_en),
    .wr_rec('{adr: data_adr, data: write_data}),
    .valid(log_valid), .rd_rec(head), .overflow(log_overflow)
  );
  assign log_adr = head.adr;
  assign log_data = head.data;
  // scratch writes never decide, so a timeout on that cycle still fires
  assign decide = mem_write && data_adr != SCRATCH_ADDR;
  assign timeout = TIMEOUT_CYCLES != 0 && cycle_count == 32'(TIMEOUT_CYCLES) - 32'd1;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= RUN;
    else state <= state_n;
  always_comb begin
    code_n = state != RUN ? FC_NONE
           : decide ? (data_adr == PASS_ADDR ? (write_data == PASS_DATA ? FC_NONE : FC_BAD_DATA) : FC_BAD_ADR)
           : timeout ? FC_TIMEOUT : FC_NONE;
    state_n = state != RUN ? state
            : decide && data_adr == PASS_ADDR && write_data == PASS_DATA ? PASS
            : code_n != FC_NONE ? FAIL : RUN;
  end
  always_comb begin
    done = state != RUN;
    pass = state == PASS;
    fail = state == FAIL;
    fail_code = code_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      code_q <= FC_NONE;
      fail_adr <= '0;
      fail_data <= '0;
      cycle_count <= '0;
    end else begin
      if (state == RUN && state_n == FAIL) begin
        code_q <= code_n;
        fail_adr <= code_n == FC_TIMEOUT ? 32'd0 : data_adr;
        fail_data <= code_n == FC_TIMEOUT ? 32'd0 : write_data;
      end
      if (state == RUN && cycle_count != '1) cycle_count <= cycle_count + 32'd1;
    end
endmodule
